// File: rtl/aoi_logic_pipe.sv
// Two-stage valid/ready AND-OR-INVERT logic pipe with a saturating output-transfer counter.
// Stage 1 captures operands and mode; stage 2 captures the per-lane e/f/g terms.

module aoi_lane (
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);
  always_comb begin
    e = 1'b0;
    f = 1'b0;
    g = 1'b0;
    case (mode)
      2'b00: begin e = a & b; f = c & d; g = ~(e | f); end
      2'b01: begin e = a | b; f = c | d; g = ~(e & f); end
      2'b10: begin e = a & b; f = c & d; g = e | f;    end
      2'b11: begin e = a | b; f = c | d; g = e & f;    end
      default: ;
    endcase
  end
endmodule

module aoi_logic_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] xfer_cnt
);
  localparam int STAGES = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] g;
  } rsp_t;

  req_t              s1_q;
  rsp_t              s2_d, s2_q;
  logic [STAGES:1]   vld_pipe;
  logic              s1_load, s2_load, out_xfer;

  // Stage 2 frees up whenever its result is taken, so a full pipe still moves at one per cycle.
  assign out_xfer = vld_pipe[2] & out_ready;
  assign s2_load  = ~vld_pipe[2] | out_ready;
  assign s1_load  = ~vld_pipe[1] | s2_load;
  assign in_ready = s1_load;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    aoi_lane u_lane (
      .mode (s1_q.mode),
      .a    (s1_q.a[i]),
      .b    (s1_q.b[i]),
      .c    (s1_q.c[i]),
      .d    (s1_q.d[i]),
      .e    (s2_d.e[i]),
      .f    (s2_d.f[i]),
      .g    (s2_d.g[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_load) vld_pipe[1] <= in_valid;
      if (s1_load && in_valid) s1_q <= {mode, a, b, c, d};
      if (s2_load) vld_pipe[2] <= vld_pipe[1];
      if (s2_load && vld_pipe[1]) s2_q <= s2_d;
    end
  end

  // Clear has priority over a coincident transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             xfer_cnt <= '0;
    else if (cnt_clr)                       xfer_cnt <= '0;
    else if (out_xfer && xfer_cnt != CNT_MAX) xfer_cnt <= xfer_cnt + 1'b1;
  end

  assign out_valid = vld_pipe[2];
  assign e = s2_q.e;
  assign f = s2_q.f;
  assign g = s2_q.g;
endmodule

// File: tb/tb_aoi_logic_pipe.sv
// Scoreboard bench for aoi_logic_pipe: stimulus pushes expected e/f/g, a monitor pops on each output transfer.

module tb_aoi_logic_pipe;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a, b, c, d, e, f, g;
  logic [CNT_W-1:0] xfer_cnt;

  int               n_chk = 0;
  int               n_fail = 0;
  int               cyc = 0;
  logic [11:0]      sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aoi_logic_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .e(e), .f(f), .g(g),
    .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: first level is AND for modes x0 and OR for x1, second level the dual; bit1=0 inverts.
  function automatic logic [11:0] model(input logic [1:0] m, input logic [3:0] ia, ib, ic, id);
    logic [3:0] x, y, z;
    x = m[0] ? (ia | ib) : (ia & ib);
    y = m[0] ? (ic | id) : (ic & id);
    z = m[0] ? (x & y) : (x | y);
    if (!m[1]) z = ~z;
    return {x, y, z};
  endfunction

  task automatic send(input logic [1:0] m, input logic [3:0] ia, ib, ic, id, input logic [11:0] ex);
    mode = m; a = ia; b = ib; c = ic; d = id; in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(ex);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 30; t++) begin
      if (sbq.size() == 0 && !out_valid) return;
      @(posedge clk); #1;
    end
    chk("drain_timeout", sbq.size(), 32'd0);
  endtask

  // Monitor: compare every output transfer against the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_result: got %0h expected none", {e, f, g});
        end else begin
          chk("result", {20'd0, e, f, g}, {20'd0, sbq.pop_front()});
        end
      end
    end
  end

  initial begin
    logic [3:0]  sa, sb2, sc, sd;
    logic [4:0]  cmb;
    logic [12:0] hold;
    int          c0;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    mode = 2'b00; a = '0; b = '0; c = '0; d = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_efg", {e, f, g}, 0);
    chk("rst_cnt", xfer_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Directed AOI with latency check, then OAI.
    send(2'b00, 4'b1100, 4'b1010, 4'b0011, 4'b0101, {4'b1000, 4'b0001, 4'b0110});
    in_valid = 1'b0;
    @(negedge clk) chk("lat_edge1_valid", out_valid, 0);
    @(negedge clk) chk("lat_edge2_valid", out_valid, 1);
    drain();
    send(2'b01, 4'b1100, 4'b1010, 4'b0011, 4'b0101, {4'b1110, 4'b0111, 4'b1001});
    in_valid = 1'b0;
    drain();

    // Sweep: lane 0 walks all 16 combinations, other lanes get rotated combinations.
    c0 = cyc;
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 16; i++) begin
        for (int k = 0; k < 4; k++) begin
          cmb = 5'((i + 5 * k) % 16);
          sa[k] = cmb[3]; sb2[k] = cmb[2]; sc[k] = cmb[1]; sd[k] = cmb[0];
        end
        send(2'(m), sa, sb2, sc, sd, model(2'(m), sa, sb2, sc, sd));
      end
    end
    in_valid = 1'b0;
    chk("sweep_throughput_cycles", cyc - c0, 64);
    drain();

    // Backpressure: two sets fit, the third must wait.
    out_ready = 1'b0;
    send(2'b10, 4'b0110, 4'b0011, 4'b1001, 4'b1100, model(2'b10, 4'b0110, 4'b0011, 4'b1001, 4'b1100));
    send(2'b11, 4'b0110, 4'b0011, 4'b1001, 4'b1100, model(2'b11, 4'b0110, 4'b0011, 4'b1001, 4'b1100));
    mode = 2'b00; a = 4'b1111; b = 4'b0101; c = 4'b1010; d = 4'b1111; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    hold = {out_valid, e, f, g};
    @(negedge clk);
    chk("bp_hold_stable", {out_valid, e, f, g}, hold);
    chk("bp_first_result", {e, f, g}, model(2'b10, 4'b0110, 4'b0011, 4'b1001, 4'b1100));
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b00, 4'b1111, 4'b0101, 4'b1010, 4'b1111, {4'b0101, 4'b1010, 4'b0000});
    in_valid = 1'b0;
    drain();

    // Counter: count, saturate, clear beating a coincident transfer.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("cnt_cleared", xfer_cnt, 0);
    for (int i = 0; i < 5; i++)
      send(2'b10, 4'(i), 4'hF, 4'h0, 4'h0, {4'(i), 4'h0, 4'(i)});
    in_valid = 1'b0;
    drain();
    chk("cnt_5", xfer_cnt, 5);
    for (int i = 0; i < 12; i++)
      send(2'b11, 4'(i), 4'h0, 4'hF, 4'h0, {4'(i), 4'hF, 4'(i)});
    in_valid = 1'b0;
    drain();
    chk("cnt_saturate", xfer_cnt, 15);
    send(2'b01, 4'h0, 4'h0, 4'h0, 4'h0, 12'h00F);
    in_valid = 1'b0;
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(negedge clk) chk("clr_xfer_coincident", out_valid & out_ready, 1);
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", xfer_cnt, 0);
    drain();

    // Reset with both stages full.
    send(2'b00, 4'h3, 4'h3, 4'h0, 4'h0, {4'h3, 4'h0, 4'hC});
    in_valid = 1'b0;
    drain();
    chk("cnt_pre_reset", xfer_cnt, 1);
    out_ready = 1'b0;
    send(2'b10, 4'hF, 4'hF, 4'h0, 4'h0, 12'hF0F);
    send(2'b11, 4'hF, 4'h0, 4'h0, 4'hF, 12'hFFF);
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_efg", {e, f, g}, 0);
    chk("mid_rst_cnt", xfer_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    sbq.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send(2'b01, 4'b1000, 4'b0001, 4'b0100, 4'b0010, {4'b1001, 4'b0110, 4'b1111});
    in_valid = 1'b0;
    drain();
    chk("post_rst_cnt", xfer_cnt, 1);
    chk("sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
